wf68k30l_regfile_sb: RTL and testbench

WF68K30L_REGFILE_SB -- requirements
Module: wf68k30l_regfile_sb

---
 rtl/wf68k30l_regfile_sb_pkg.sv | 23 ++
 rtl/wf68k30l_regfile_sb_if.sv | 32 +++
 rtl/wf68k30l_sb_counter.sv | 40 ++++
 rtl/wf68k30l_regfile_sb.sv | 90 +++++++++
 tb/tb_wf68k30l_regfile_sb.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wf68k30l_regfile_sb_pkg.sv
// Shared operand-size encoding and byte-lane helper for the WF68K30L register file.
package wf68k30L_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_LONG = 2'b10,
    SZ_WORD = 2'b11
  } op_size_t;

  // True when byte lane 'lane' (0 = bits [7:0]) is written by an operand of size 'sz'.
  function automatic logic lane_en(input logic [1:0] sz, input int unsigned lane);
    logic en;
    case (sz)
      SZ_BYTE: en = (lane == 0);
      SZ_WORD: en = (lane < 2);
      SZ_LONG: en = 1'b1;
      default: en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/wf68k30l_regfile_sb_if.sv
// Write/mark/read bundle of the register file with scoreboard.
interface wf68k30l_regfile_sb_if #(
  parameter int NREGS = 8,
  parameter int DW    = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NWR-1:0]    WR_EN;
  logic [NWR*AW-1:0] WR_SEL;
  logic [NWR*2-1:0]  WR_SIZE;
  logic [NWR*DW-1:0] WR_DATA;
  logic [NWR-1:0]    WR_RETIRE;
  logic [NWR-1:0]    MARK_EN;
  logic [NWR*AW-1:0] MARK_SEL;
  logic              UNMARK;
  logic [NRD*AW-1:0] RD_SEL;
  logic [NRD*DW-1:0] RD_DATA;
  logic [NRD-1:0]    RD_BUSY;
  logic              MARK_REJ;

  modport master (
    output WR_EN, WR_SEL, WR_SIZE, WR_DATA, WR_RETIRE, MARK_EN, MARK_SEL, UNMARK, RD_SEL,
    input  RD_DATA, RD_BUSY, MARK_REJ
  );

  modport slave (
    input  WR_EN, WR_SEL, WR_SIZE, WR_DATA, WR_RETIRE, MARK_EN, MARK_SEL, UNMARK, RD_SEL,
    output RD_DATA, RD_BUSY, MARK_REJ
  );
endinterface

// File: rtl/wf68k30l_sb_counter.sv
// Pending-write counter for one register: saturating marks, zero-floored retires, flush.
module wf68k30l_sb_counter #(
  parameter int CW = 2,
  parameter int MW = 2
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          unmark,
  input  logic [MW-1:0] mark_cnt,
  input  logic [MW-1:0] retire_cnt,
  output logic          busy,
  output logic          reject
);
  localparam int SW   = CW + MW + 1;
  localparam int MAXV = (1 << CW) - 1;

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [SW-1:0] sum_marked;
  logic [SW-1:0] base;
  logic          over;

  always_comb begin
    sum_marked = SW'(count_reg) + SW'(mark_cnt);
    over       = sum_marked > SW'(MAXV);
    // An overflowing cycle refuses every mark to this register, not just the excess.
    base       = over ? SW'(count_reg) : sum_marked;
    reject     = over && !unmark;
    count_next = '0;
    if (!unmark && (base > SW'(retire_cnt)))
      count_next = CW'(base - SW'(retire_cnt));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) count_reg <= '0;
    else          count_reg <= count_next;
  end

  assign busy = (count_reg != '0);
endmodule

// File: rtl/wf68k30l_regfile_sb.sv
// Register file with sized byte-lane writes, optional write forwarding and per-register pending-write scoreboard.
module wf68k30l_regfile_sb
  import wf68k30L_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int DW     = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int CW     = 2,
  parameter int BYPASS = 1
) (
  input logic CLK,
  input logic RESET_N,
  wf68k30l_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int NB = DW / 8;
  localparam int MW = $clog2(NWR + 1);

  logic [NREGS-1:0][DW-1:0] stored;
  logic [NREGS-1:0][DW-1:0] merged;
  logic [NREGS-1:0]         busy_w;
  logic [NREGS-1:0]         rej_w;
  logic                     mark_rej_reg;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic [DW-1:0] data_reg;
    logic [DW-1:0] data_next;
    logic [MW-1:0] mark_cnt;
    logic [MW-1:0] retire_cnt;

    // Ports are scanned low to high so the highest-index writer owns each shared lane.
    always_comb begin
      data_next = data_reg;
      for (int p = 0; p < NWR; p++) begin
        if (bus.WR_EN[p] && (bus.WR_SEL[p*AW +: AW] == AW'(gi))) begin
          for (int b = 0; b < NB; b++) begin
            if (lane_en(bus.WR_SIZE[p*2 +: 2], unsigned'(b)))
              data_next[b*8 +: 8] = bus.WR_DATA[p*DW + b*8 +: 8];
          end
        end
      end
    end

    always_comb begin
      mark_cnt   = '0;
      retire_cnt = '0;
      for (int p = 0; p < NWR; p++) begin
        if (bus.MARK_EN[p] && (bus.MARK_SEL[p*AW +: AW] == AW'(gi)))
          mark_cnt = mark_cnt + MW'(1);
        if (bus.WR_EN[p] && bus.WR_RETIRE[p] && (bus.WR_SEL[p*AW +: AW] == AW'(gi)))
          retire_cnt = retire_cnt + MW'(1);
      end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) data_reg <= '0;
      else          data_reg <= data_next;
    end

    assign stored[gi] = data_reg;
    assign merged[gi] = data_next;

    wf68k30l_sb_counter #(.CW(CW), .MW(MW)) u_cnt (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .unmark     (bus.UNMARK),
      .mark_cnt   (mark_cnt),
      .retire_cnt (retire_cnt),
      .busy       (busy_w[gi]),
      .reject     (rej_w[gi])
    );
  end

  // Reads are forced to zero while reset is held so forwarded write data cannot leak out.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] sel;
    assign sel = bus.RD_SEL[gi*AW +: AW];
    assign bus.RD_DATA[gi*DW +: DW] = !RESET_N ? '0 :
                                      (BYPASS != 0) ? merged[sel] : stored[sel];
    assign bus.RD_BUSY[gi] = RESET_N & busy_w[sel];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) mark_rej_reg <= 1'b0;
    else          mark_rej_reg <= |rej_w;
  end

  assign bus.MARK_REJ = mark_rej_reg;
endmodule

// File: tb/tb_wf68k30l_regfile_sb.sv
// Scoreboard bench for wf68k30l_regfile_sb: directed scenarios plus random traffic against a lane-mask model.
module tb_wf68k30l_regfile_sb;
  import wf68k30L_pkg::*;

  localparam int NREGS = 8, DW = 32, NRD = 2, NWR = 2, CW = 2, BYPASS = 1, AW = 3;
  localparam int CMAX = 3;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  wf68k30l_regfile_sb_if #(.NREGS(NREGS), .DW(DW), .NRD(NRD), .NWR(NWR)) bus ();

  wf68k30l_regfile_sb #(
    .NREGS(NREGS), .DW(DW), .NRD(NRD), .NWR(NWR), .CW(CW), .BYPASS(BYPASS)
  ) u_dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        rej;
    int          ckind;   // 0 none, 1 RD_DATA[cport], 2 RD_BUSY[cport], 3 MARK_REJ
    int          cport;
    logic [31:0] cval;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs[NREGS];
  int          m_cnt[NREGS];
  bit          m_rej;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 32'h0000_00FF;
      SZ_WORD: return 32'h0000_FFFF;
      SZ_LONG: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  // Stored value overlaid with this cycle's writes, applied in port order.
  function automatic logic [31:0] model_view(input int r);
    logic [31:0] v;
    logic [31:0] m;
    v = m_regs[r];
    for (int p = 0; p < NWR; p++) begin
      if (bus.WR_EN[p] && int'(bus.WR_SEL[p*AW +: AW]) == r) begin
        m = mask_of(bus.WR_SIZE[p*2 +: 2]);
        v = (v & ~m) | (bus.WR_DATA[p*DW +: DW] & m);
      end
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = 32'h0;
      m_cnt[r]  = 0;
    end
    m_rej = 1'b0;
  endtask

  task automatic model_update();
    logic [31:0] nv[NREGS];
    bit rej_any;
    int nm, nr, t;
    rej_any = 1'b0;
    for (int r = 0; r < NREGS; r++) nv[r] = model_view(r);
    for (int r = 0; r < NREGS; r++) begin
      nm = 0;
      nr = 0;
      for (int p = 0; p < NWR; p++) begin
        if (bus.MARK_EN[p] && int'(bus.MARK_SEL[p*AW +: AW]) == r) nm++;
        if (bus.WR_EN[p] && bus.WR_RETIRE[p] && int'(bus.WR_SEL[p*AW +: AW]) == r) nr++;
      end
      if (bus.UNMARK) begin
        m_cnt[r] = 0;
      end else begin
        t = m_cnt[r] + nm;
        if (t > CMAX) begin
          rej_any = 1'b1;
          t = m_cnt[r];
        end
        m_cnt[r] = (t > nr) ? t - nr : 0;
      end
      m_regs[r] = nv[r];
    end
    m_rej = rej_any;
  endtask

  task automatic clear_in();
    bus.WR_EN     = '0;
    bus.WR_SEL    = '0;
    bus.WR_SIZE   = '0;
    bus.WR_DATA   = '0;
    bus.WR_RETIRE = '0;
    bus.MARK_EN   = '0;
    bus.MARK_SEL  = '0;
    bus.UNMARK    = 1'b0;
    bus.RD_SEL    = '0;
  endtask

  task automatic wr(input int p, input int r, input logic [1:0] sz, input logic [31:0] d, input bit ret);
    bus.WR_EN[p]               = 1'b1;
    bus.WR_SEL[p*AW +: AW]     = AW'(r);
    bus.WR_SIZE[p*2 +: 2]      = sz;
    bus.WR_DATA[p*DW +: DW]    = d;
    bus.WR_RETIRE[p]           = ret;
  endtask

  task automatic mark(input int p, input int r);
    bus.MARK_EN[p]           = 1'b1;
    bus.MARK_SEL[p*AW +: AW] = AW'(r);
  endtask

  task automatic rd(input int p, input int r);
    bus.RD_SEL[p*AW +: AW] = AW'(r);
  endtask

  // Push the expected outputs for the inputs now on the bus, then advance the model across the edge.
  task automatic step(input string tag, input int ckind = 0, input int cport = 0, input logic [31:0] cval = 0);
    exp_t e;
    int s0, s1;
    s0 = int'(bus.RD_SEL[0 +: AW]);
    s1 = int'(bus.RD_SEL[AW +: AW]);
    e.tag   = tag;
    e.d0    = (BYPASS != 0) ? model_view(s0) : m_regs[s0];
    e.d1    = (BYPASS != 0) ? model_view(s1) : m_regs[s1];
    e.busy  = {m_cnt[s1] != 0, m_cnt[s0] != 0};
    e.rej   = m_rej;
    e.ckind = ckind;
    e.cport = cport;
    e.cval  = cval;
    sb.push_back(e);
    @(posedge CLK);
    model_update();
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("[TB] %s rd0=%08h rd1=%08h busy=%b rej=%b", e.tag,
                 bus.RD_DATA[31:0], bus.RD_DATA[63:32], bus.RD_BUSY, bus.MARK_REJ);
        chk({e.tag, ".rd0"}, bus.RD_DATA[31:0], e.d0);
        chk({e.tag, ".rd1"}, bus.RD_DATA[63:32], e.d1);
        chk({e.tag, ".busy"}, {30'h0, bus.RD_BUSY}, {30'h0, e.busy});
        chk({e.tag, ".rej"}, {31'h0, bus.MARK_REJ}, {31'h0, e.rej});
        case (e.ckind)
          1: chk({e.tag, ".const_data"}, bus.RD_DATA[e.cport*DW +: DW], e.cval);
          2: chk({e.tag, ".const_busy"}, {31'h0, bus.RD_BUSY[e.cport]}, e.cval);
          3: chk({e.tag, ".const_rej"}, {31'h0, bus.MARK_REJ}, e.cval);
          default: ;
        endcase
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    model_reset();
    clear_in();
    #12;
    chk("reset.rd", bus.RD_DATA, 64'h0);
    chk("reset.busy", {30'h0, bus.RD_BUSY}, 32'h0);
    chk("reset.rej", {31'h0, bus.MARK_REJ}, 32'h0);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    // Sized writes preserve untouched lanes
    clear_in(); wr(0, 3, SZ_LONG, 32'h1234_5678, 0); rd(0, 3); step("w_long_d3");
    clear_in(); wr(0, 3, SZ_BYTE, 32'hFFFF_FFAB, 0); rd(0, 3); step("w_byte_d3", 1, 0, 32'h1234_56AB);
    clear_in(); rd(0, 3); step("rd_d3", 1, 0, 32'h1234_56AB);
    clear_in(); wr(1, 3, 2'b00, 32'hFFFF_FFFF, 0); rd(0, 3); step("w_none_d3");
    clear_in(); rd(1, 3); step("rd_d3_none", 1, 1, 32'h1234_56AB);

    // Same-cycle multi-port merge and priority
    clear_in(); wr(0, 5, SZ_WORD, 32'h0000_1111, 0); wr(1, 5, SZ_BYTE, 32'h0000_0022, 0); rd(0, 5);
    step("merge_d5", 1, 0, 32'h0000_1122);
    clear_in(); rd(1, 5); step("rd_d5", 1, 1, 32'h0000_1122);
    clear_in(); wr(0, 6, SZ_BYTE, 32'h11, 0); wr(1, 6, SZ_LONG, 32'hCAFE_BABE, 0); rd(0, 6);
    step("prio_long_hi", 1, 0, 32'hCAFE_BABE);
    clear_in(); wr(0, 6, SZ_LONG, 32'hCAFE_BABE, 0); wr(1, 6, SZ_BYTE, 32'h11, 0); rd(1, 6);
    step("prio_byte_hi", 1, 1, 32'hCAFE_BA11);

    // Saturation: three marks fill D2, the fourth is refused
    for (int i = 0; i < 3; i++) begin
      clear_in(); mark(i % 2, 2); rd(0, 2); step("mark_d2");
    end
    clear_in(); mark(0, 2); rd(0, 2); step("mark4_d2", 2, 0, 1);
    clear_in(); rd(0, 2); step("rej_pulse", 3, 0, 1);
    clear_in(); rd(0, 2); step("rej_gone", 3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      clear_in(); wr(0, 2, SZ_NONE, 32'h0, 1); rd(0, 2); step("retire_d2", 2, 0, 1);
    end
    clear_in(); rd(0, 2); step("d2_drained", 2, 0, 0);

    // Mark+retire in one cycle holds the count; retire at zero does not wrap
    clear_in(); mark(0, 4); step("mark_d4");
    clear_in(); mark(0, 4); wr(1, 4, SZ_NONE, 32'h0, 1); rd(0, 4); step("mark_ret_d4", 2, 0, 1);
    clear_in(); rd(0, 4); step("d4_hold", 2, 0, 1);
    clear_in(); wr(0, 4, SZ_NONE, 32'h0, 1); step("ret_d4");
    clear_in(); rd(0, 4); step("d4_zero", 2, 0, 0);
    clear_in(); wr(0, 4, SZ_NONE, 32'h0, 1); step("ret_d4_at0");
    clear_in(); mark(0, 4); step("mark_d4_again");
    clear_in(); wr(0, 4, SZ_NONE, 32'h0, 1); step("ret_d4_again");
    clear_in(); rd(0, 4); step("d4_nowrap", 2, 0, 0);

    // UNMARK flushes everything, including a same-cycle mark
    clear_in(); mark(0, 0); mark(1, 7); step("mark_d0_d7");
    clear_in(); bus.UNMARK = 1'b1; mark(0, 1); rd(0, 0); rd(1, 7); step("unmark", 2, 0, 1);
    clear_in(); rd(0, 0); rd(1, 7); step("flush_d0_d7", 2, 1, 0);
    clear_in(); rd(0, 1); rd(1, 0); step("flush_d1", 2, 0, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      clear_in();
      for (int p = 0; p < NWR; p++) begin
        if ($urandom_range(0, 1) == 1)
          wr(p, $urandom_range(0, NREGS - 1), 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
      end
      bus.UNMARK = ($urandom_range(0, 15) == 0);
      if (!bus.UNMARK) begin
        for (int p = 0; p < NWR; p++)
          if ($urandom_range(0, 2) == 0) mark(p, $urandom_range(0, NREGS - 1));
      end
      rd(0, $urandom_range(0, NREGS - 1));
      rd(1, $urandom_range(0, NREGS - 1));
      step("rnd");
    end

    // Reset asserted between edges while a write and a mark are on the bus
    clear_in(); mark(0, 5); step("pre_reset_mark");
    clear_in(); wr(0, 6, SZ_LONG, 32'hDEAD_BEEF, 0); mark(1, 6); rd(0, 6); rd(1, 5);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("rst_mid.rd", bus.RD_DATA, 64'h0);
    chk("rst_mid.busy", {30'h0, bus.RD_BUSY}, 32'h0);
    chk("rst_mid.rej", {31'h0, bus.MARK_REJ}, 32'h0);
    @(posedge CLK);
    #2;
    chk("rst_hold.rd", bus.RD_DATA, 64'h0);
    chk("rst_hold.busy", {30'h0, bus.RD_BUSY}, 32'h0);
    model_reset();
    clear_in();
    rd(0, 6); rd(1, 5);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    clear_in(); rd(0, 6); rd(1, 5); step("post_rst_d6", 1, 0, 32'h0);
    clear_in(); wr(0, 6, SZ_LONG, 32'h0BAD_F00D, 0); mark(1, 6); step("post_rst_w");
    clear_in(); rd(1, 6); step("post_rst_rd", 1, 1, 32'h0BAD_F00D);
    clear_in(); rd(0, 6); step("post_rst_busy", 2, 0, 1);

    clear_in();
    @(negedge CLK);
    repeat (2) @(posedge CLK);
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
